instr_queue: RTL and testbench

Circular FIFO of decoded instructions (`pci_t`) between the decode stage and the reorder buffer. Decode pushes one instruction per cycle. The ROB reads the head through a show-ahead output and pops it with its `instr_q_dequeue` signal. Flush empties the queue in one cycle for branch-mispredict recovery.

---
 rtl/rv32i_types.sv | 42 ++++
 rtl/instr_queue.sv | 88 ++++++++
 tb/tb_instr_queue.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types: opcode enum, decoded-instruction bundle and its NOP value.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    rv32i_opcode opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } pci_t;

  // Cleared entry: addi x0,x0,0 shape, also used by the ROB
  localparam pci_t PCI_NOP = '{
    pc:     32'h0,
    instr:  32'h0,
    opcode: op_imm,
    funct3: 3'h0,
    funct7: 7'h0,
    rs1:    5'h0,
    rs2:    5'h0,
    rd:     5'h0,
    imm:    32'h0
  };

endpackage

// File: rtl/instr_queue.sv
// Circular decode->ROB instruction FIFO with show-ahead head and one-cycle flush.
// Optional INSTR_Q_BYPASS_EN: empty queue forwards pci_in to pci_o combinationally.
module instr_queue
  import rv32i_types::*;
#(
  parameter int size = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enqueue,
  input  pci_t                   pci_in,
  input  logic                   dequeue,
  input  logic                   flush,
  output pci_t                   pci_o,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(size):0]  count
);

  localparam int AW = $clog2(size);
  localparam int CW = AW + 1;

  pci_t            r_arr [size];
  logic [AW-1:0]   r_front;
  logic [AW-1:0]   r_rear;
  logic [CW-1:0]   r_count;

  logic w_empty_q;
  logic w_full_q;
  logic w_push;
  logic w_pop;
  logic w_byp_take;

  assign w_empty_q = (r_count == '0);
  assign w_full_q  = (r_count == CW'(size));

`ifdef INSTR_Q_BYPASS_EN
  assign w_byp_take = w_empty_q && enqueue && dequeue && !flush;
`else
  assign w_byp_take = 1'b0;
`endif

  assign w_pop  = dequeue && !w_empty_q;
  assign w_push = enqueue && (!w_full_q || dequeue) && !w_byp_take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_front <= '0;
      r_rear  <= '0;
      r_count <= '0;
      for (int i = 0; i < size; i++) r_arr[i] <= PCI_NOP;
    end else if (flush) begin
      r_front <= '0;
      r_rear  <= '0;
      r_count <= '0;
      for (int i = 0; i < size; i++) r_arr[i] <= PCI_NOP;
    end else begin
      // Pop clears first so a full-queue push into the same slot wins
      if (w_pop) begin
        r_arr[r_front] <= PCI_NOP;
        r_front        <= r_front + AW'(1);
      end
      if (w_push) begin
        r_arr[r_rear] <= pci_in;
        r_rear        <= r_rear + AW'(1);
      end
      unique case (1'b1)
        (w_push && !w_pop): r_count <= r_count + CW'(1);
        (w_pop && !w_push): r_count <= r_count - CW'(1);
        default:            r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    pci_o = r_arr[r_front];
    empty = w_empty_q;
    full  = w_full_q;
    count = r_count;
`ifdef INSTR_Q_BYPASS_EN
    if (w_empty_q && enqueue && !flush) begin
      pci_o = pci_in;
      empty = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: queue-based reference model,
// directed corner cases and randomized push/pop/flush traffic.
module tb_instr_queue;
  import rv32i_types::*;

  localparam int SIZE = 8;
`ifdef INSTR_Q_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef logic [$bits(pci_t)-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enqueue = 1'b0;
  logic dequeue = 1'b0;
  logic flush = 1'b0;
  pci_t pci_in = PCI_NOP;
  pci_t pci_o;
  logic empty;
  logic full;
  logic [$clog2(SIZE):0] count;

  instr_queue #(.size(SIZE)) dut (
    .clk     (clk),
    .rst     (rst),
    .enqueue (enqueue),
    .pci_in  (pci_in),
    .dequeue (dequeue),
    .flush   (flush),
    .pci_o   (pci_o),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  bit   chk_on = 1'b0;
  pci_t q[$];

  task automatic chk(input string nm, input vec_t act, input vec_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic pci_t mk(input logic [31:0] pc);
    pci_t p;
    p = PCI_NOP;
    p.pc = pc;
    p.instr = $urandom;
    p.rd = 5'($urandom);
    p.rs1 = 5'($urandom);
    p.imm = $urandom;
    case ($urandom_range(0, 2))
      0: p.opcode = op_reg;
      1: p.opcode = op_load;
      default: p.opcode = op_imm;
    endcase
    return p;
  endfunction

  // Reference: a FIFO of instructions, updated by the rules at each edge
  task automatic model_step();
    int n;
    bit take, pop, push;
    if (!rst || flush) begin
      q.delete();
      return;
    end
    n = q.size();
    take = BYP && (n == 0) && enqueue && dequeue;
    pop = dequeue && (n != 0);
    push = enqueue && ((n != SIZE) || dequeue) && !take;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(pci_in);
  endtask

  task automatic cyc(input bit e, input pci_t p, input bit d, input bit f);
    enqueue = e;
    pci_in = p;
    dequeue = d;
    flush = f;
    @(posedge clk);
    model_step();
    #1;
    enqueue = 1'b0;
    dequeue = 1'b0;
    flush = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      automatic int n = q.size();
      automatic bit byp = BYP && (n == 0) && enqueue && !flush && rst;
      automatic pci_t ep;
      if (byp) ep = pci_in;
      else if (n != 0) ep = q[0];
      else ep = PCI_NOP;
      chk("count", vec_t'(count), vec_t'(n));
      chk("full", vec_t'(full), vec_t'(n == SIZE));
      chk("empty", vec_t'(empty), vec_t'((n == 0) && !byp));
      chk("pci_o", vec_t'(pci_o), vec_t'(ep));
    end
  end

  initial begin
    int pe, pd;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", vec_t'(count), vec_t'(0));
    chk("rst_empty", vec_t'(empty), vec_t'(1));
    chk("rst_full", vec_t'(full), vec_t'(0));
    chk("rst_pci", vec_t'(pci_o), vec_t'(PCI_NOP));
    rst = 1'b1;
    chk_on = 1'b1;

    for (int i = 0; i < 8; i++) cyc(1, mk(32'(i * 4)), 0, 0);
    chk("fill_count", vec_t'(count), vec_t'(8));
    chk("fill_full", vec_t'(full), vec_t'(1));
    chk("fill_head", vec_t'(pci_o.pc), vec_t'(32'h00));
    cyc(1, mk(32'h20), 0, 0);
    chk("ovf_count", vec_t'(count), vec_t'(8));
    chk("ovf_head", vec_t'(pci_o.pc), vec_t'(32'h00));

    cyc(1, mk(32'h20), 1, 0);
    chk("fullpp_count", vec_t'(count), vec_t'(8));
    chk("fullpp_head", vec_t'(pci_o.pc), vec_t'(32'h04));
    repeat (7) cyc(0, PCI_NOP, 1, 0);
    chk("wrap_head", vec_t'(pci_o.pc), vec_t'(32'h20));
    chk("wrap_count", vec_t'(count), vec_t'(1));

    cyc(1, mk(32'h40), 1, 0);
    chk("one_head40", vec_t'(pci_o.pc), vec_t'(32'h40));
    cyc(1, mk(32'h44), 1, 0);
    chk("one_count", vec_t'(count), vec_t'(1));
    chk("one_head44", vec_t'(pci_o.pc), vec_t'(32'h44));
    chk("one_empty", vec_t'(empty), vec_t'(0));

    cyc(0, PCI_NOP, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, mk(32'h50 + 32'(i * 4)), 0, 0);
    chk("pre_flush", vec_t'(count), vec_t'(5));
    cyc(1, mk(32'h60), 0, 1);
    chk("flush_count", vec_t'(count), vec_t'(0));
    chk("flush_empty", vec_t'(empty), vec_t'(1));
    chk("flush_pci", vec_t'(pci_o), vec_t'(PCI_NOP));
    cyc(1, mk(32'h80), 0, 0);
    chk("flush_idx0", vec_t'(dut.r_arr[0].pc), vec_t'(32'h80));
    chk("flush_head", vec_t'(pci_o.pc), vec_t'(32'h80));

    cyc(1, mk(32'h84), 0, 0);
    cyc(1, mk(32'h88), 0, 0);
    chk("pre_rst", vec_t'(count), vec_t'(3));
    #1;
    rst = 1'b0;
    q.delete();
    #1;
    chk("arst_empty", vec_t'(empty), vec_t'(1));
    chk("arst_pci", vec_t'(pci_o), vec_t'(PCI_NOP));
    chk("arst_count", vec_t'(count), vec_t'(0));
    @(posedge clk);
    model_step();
    #1;
    rst = 1'b1;

    enqueue = 1'b1;
    dequeue = 1'b1;
    pci_in = mk(32'h100);
    #2;
    if (BYP) begin
      chk("byp_pci", vec_t'(pci_o.pc), vec_t'(32'h100));
      chk("byp_empty", vec_t'(empty), vec_t'(0));
    end else begin
      chk("nbyp_empty", vec_t'(empty), vec_t'(1));
    end
    @(posedge clk);
    model_step();
    #1;
    enqueue = 1'b0;
    dequeue = 1'b0;
    if (BYP) begin
      chk("byp_count", vec_t'(count), vec_t'(0));
    end else begin
      chk("nbyp_count", vec_t'(count), vec_t'(1));
      chk("nbyp_head", vec_t'(pci_o.pc), vec_t'(32'h100));
    end

    for (int i = 0; i < 3000; i++) begin
      case ((i / 150) % 3)
        0: begin pe = 80; pd = 30; end
        1: begin pe = 30; pd = 80; end
        default: begin pe = 60; pd = 60; end
      endcase
      cyc($urandom_range(0, 99) < pe, mk($urandom),
          $urandom_range(0, 99) < pd, $urandom_range(0, 63) == 0);
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
